// File: rtl/pci_reset_pkg.sv
// Shared definitions for the PCI reset driver: the reset-sequencer state
// encoding, the default counter width and a small decode helper.
package pci_reset_pkg;

    // Fixed 2-bit state codes; other blocks may decode these directly.
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_ASSERT    = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    // Default width of the shared assert/timeout counter.
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK = ST_WAIT_LOCK,
        ASSERT    = ST_ASSERT,
        RELEASE   = ST_RELEASE,
        RUN       = ST_RUN
    } state_e;

    // RST# is driven low while the PLL is unlocked and during the timed
    // assert window. In RELEASE and RUN the pad is only observed.
    function automatic logic drives_reset(state_e s);
        return (s == WAIT_LOCK) || (s == ASSERT);
    endfunction

endpackage : pci_reset_pkg

// File: rtl/pci_reset_sync_2ff.sv
// Two-flop synchroniser for the observed PCI reset. A synchronous reset
// forces both stages to 1, so the bus reads as "in reset" until the pad
// is actually seen released.
module pci_reset_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next-state of the two stages: a plain shift of the asynchronous input.
    always_comb begin
        meta_d = d_async;
        sync_d = meta_q;
    end

    // Register both stages; reset puts the chain into the "in reset" state.
    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their pre-edge inputs; blocking here would collapse the chain
    // into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : pci_reset_sync_2ff

// File: rtl/pci_reset_driver.sv
// Host-side PCI reset generator: the drive half of the RST# pad.
//
// Sequences power-up, PLL-lock, software and externally observed resets,
// drives the registered pad enable pci_reset_out_oe_comb (1 pulls RST# low)
// and reports when the bus has left reset.
//
// Build option: define PCI_RESET_RELEASE_TIMEOUT_EN to bound the wait for
// the observed reset to release. When undefined, RELEASE waits forever and
// release_error is tied low.
module pci_reset_driver
    import pci_reset_pkg::*;
#(
    parameter int ASSERT_CLKS          = 33333,
    parameter int CNT_W                = CNT_W_DEFAULT,
    parameter int RELEASE_TIMEOUT_CLKS = 1024
) (
    input  logic pci_clk,
    input  logic pci_reset_comb,
    input  logic pll_locked,
    input  logic sw_reset_req,
    input  logic ext_reset_clear,
    input  logic pci_reset_raw,
    output logic pci_reset_out_oe_comb,
    output logic pci_reset_sync,
    output logic reset_busy,
    output logic reset_done,
    output logic ext_reset_seen,
    output logic release_error
);

    // Elaboration-time sanity checks on the counter sizing.
    if (ASSERT_CLKS < 2) begin : g_bad_assert_clks
        $error("pci_reset_driver: ASSERT_CLKS must be >= 2");
    end
    if (ASSERT_CLKS >= (2 ** CNT_W)) begin : g_bad_assert_width
        $error("pci_reset_driver: ASSERT_CLKS does not fit in CNT_W bits");
    end
    if ((RELEASE_TIMEOUT_CLKS < 1) || (RELEASE_TIMEOUT_CLKS >= (2 ** CNT_W))) begin : g_bad_timeout
        $error("pci_reset_driver: RELEASE_TIMEOUT_CLKS out of range for CNT_W");
    end

    // Counter reload values: loading N-1 and leaving on zero gives N cycles.
    localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(ASSERT_CLKS - 1);
`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_TIMEOUT_CLKS - 1);
`endif

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             oe_q,       oe_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             ext_seen_q, ext_seen_d;
    logic             bus_in_reset;

    // Bring the asynchronous pad observation into the pci_clk domain.
    pci_reset_sync_2ff u_sync (
        .clk     (pci_clk),
        .rst     (pci_reset_comb),
        .d_async (pci_reset_raw),
        .q       (bus_in_reset)
    );

`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
    logic rel_err_q, rel_err_d;
`endif

    // Next-state, counter and flag logic for the reset sequencer.
    // NOTE: every signal written here gets a default before the case
    // statement; any path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        ext_seen_d = ext_reset_clear ? 1'b0 : ext_seen_q;
`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
        rel_err_d  = rel_err_q;
`endif

        unique case (state_q)
            WAIT_LOCK: begin
                if (pll_locked) begin
                    state_d = ASSERT;
                    cnt_d   = ASSERT_LOAD;
                end
            end

            ASSERT: begin
                if (!pll_locked) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_d = RELEASE;
`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
                    cnt_d   = RELEASE_LOAD;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RELEASE: begin
                if (!pll_locked) begin
                    state_d = WAIT_LOCK;
                end else if (!bus_in_reset) begin
                    state_d = RUN;
                    done_d  = 1'b1;
`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
                end else if (cnt_q == '0) begin
                    // Pad never released: give up, flag it and carry on.
                    state_d   = RUN;
                    done_d    = 1'b1;
                    rel_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
`endif
                end
            end

            RUN: begin
                if (!pll_locked) begin
                    state_d = WAIT_LOCK;
                end else if (sw_reset_req) begin
                    state_d = ASSERT;
                    cnt_d   = ASSERT_LOAD;
                end else if (bus_in_reset) begin
                    // Someone else is holding RST#; wait for it to release.
                    state_d    = RELEASE;
                    ext_seen_d = 1'b1;
`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
                    cnt_d      = RELEASE_LOAD;
`endif
                end
            end

            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Outputs follow the state being entered so they stay registered.
        oe_d   = drives_reset(state_d);
        busy_d = (state_d != RUN);
    end

    // Sequencer state, counter and registered outputs; chip reset wins.
    always_ff @(posedge pci_clk) begin
        if (pci_reset_comb) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            oe_q       <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            ext_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ext_seen_q <= ext_seen_d;
        end
    end

`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
    // Sticky release-timeout flag, cleared only by chip reset.
    always_ff @(posedge pci_clk) begin
        if (pci_reset_comb) begin
            rel_err_q <= 1'b0;
        end else begin
            rel_err_q <= rel_err_d;
        end
    end

    assign release_error = rel_err_q;
`else
    assign release_error = 1'b0;
`endif

    assign pci_reset_out_oe_comb = oe_q;
    assign pci_reset_sync        = bus_in_reset;
    assign reset_busy            = busy_q;
    assign reset_done            = done_q;
    assign ext_reset_seen        = ext_seen_q;

endmodule : pci_reset_driver

// File: tb/tb_pci_reset_driver.sv
// Directed testbench for pci_reset_driver with ASSERT_CLKS=8 and
// RELEASE_TIMEOUT_CLKS=16. The pad is modelled as a wired-OR: the observed
// reset is high while the DUT drives it or while an external agent does.
// Expected values are packed as {oe, sync, busy, done, ext_seen, rel_err}.
module tb_pci_reset_driver;

    localparam int ASSERT_CLKS          = 8;
    localparam int RELEASE_TIMEOUT_CLKS = 16;

`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
    localparam logic ERR_AFTER_TIMEOUT = 1'b1;
`else
    localparam logic ERR_AFTER_TIMEOUT = 1'b0;
`endif

    logic pci_clk = 1'b0;
    logic pci_reset_comb;
    logic pll_locked;
    logic sw_reset_req;
    logic ext_reset_clear;
    logic pci_reset_raw;
    logic pci_reset_out_oe_comb;
    logic pci_reset_sync;
    logic reset_busy;
    logic reset_done;
    logic ext_reset_seen;
    logic release_error;
    logic ext_raw;
    logic [5:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    pci_reset_driver #(
        .ASSERT_CLKS          (ASSERT_CLKS),
        .CNT_W                (16),
        .RELEASE_TIMEOUT_CLKS (RELEASE_TIMEOUT_CLKS)
    ) dut (
        .pci_clk               (pci_clk),
        .pci_reset_comb        (pci_reset_comb),
        .pll_locked            (pll_locked),
        .sw_reset_req          (sw_reset_req),
        .ext_reset_clear       (ext_reset_clear),
        .pci_reset_raw         (pci_reset_raw),
        .pci_reset_out_oe_comb (pci_reset_out_oe_comb),
        .pci_reset_sync        (pci_reset_sync),
        .reset_busy            (reset_busy),
        .reset_done            (reset_done),
        .ext_reset_seen        (ext_reset_seen),
        .release_error         (release_error)
    );

    always #5 pci_clk = ~pci_clk;

    assign pci_reset_raw = pci_reset_out_oe_comb | ext_raw;
    assign obs = {pci_reset_out_oe_comb, pci_reset_sync, reset_busy,
                  reset_done, ext_reset_seen, release_error};

    task automatic step();
        @(posedge pci_clk);
        #1;
    endtask

    // Chip reset for three cycles, then two cycles waiting for PLL lock.
    task automatic test_reset();
        pci_reset_comb  = 1'b1;
        pll_locked      = 1'b0;
        sw_reset_req    = 1'b0;
        ext_reset_clear = 1'b0;
        ext_raw         = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 2) pci_reset_comb = 1'b0;
            n_cmp++;
            if (obs !== 6'b111000) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, 6'b111000);
            end
        end
    endtask

    // PLL locks: 8 assert cycles, release, done pulse, then RUN.
    task automatic test_power_up();
        logic [5:0] exp_seq [13];
        exp_seq = '{6'b111000, 6'b111000, 6'b111000, 6'b111000,
                    6'b111000, 6'b111000, 6'b111000, 6'b111000,
                    6'b011000, 6'b011000, 6'b001000, 6'b000100, 6'b000000};
        pll_locked = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL power_up[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    // Software reset from RUN; a second request mid-assert must be ignored.
    task automatic test_sw_reset();
        logic [5:0] exp_seq [13];
        exp_seq = '{6'b101000, 6'b101000, 6'b111000, 6'b111000,
                    6'b111000, 6'b111000, 6'b111000, 6'b111000,
                    6'b011000, 6'b011000, 6'b001000, 6'b000100, 6'b000000};
        sw_reset_req = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            sw_reset_req = (i == 2);
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL sw_reset[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
        end
    endtask

    // External reset pulse, then set-vs-clear collision, then a plain clear.
    task automatic test_ext_reset();
        logic [5:0] exp_seq [17];
        exp_seq = '{6'b000000, 6'b010000, 6'b011010, 6'b011010, 6'b011010,
                    6'b011010, 6'b001010, 6'b000110, 6'b000010,
                    6'b000010, 6'b010010, 6'b011010, 6'b011010,
                    6'b001010, 6'b000110, 6'b000010, 6'b000000};
        ext_raw = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL ext_reset[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i == 4)  ext_raw = 1'b0;
            if (i == 8)  ext_raw = 1'b1;
            if (i == 10) ext_reset_clear = 1'b1;
            if (i == 11) begin
                ext_reset_clear = 1'b0;
                ext_raw         = 1'b0;
            end
            if (i == 15) ext_reset_clear = 1'b1;
            if (i == 16) ext_reset_clear = 1'b0;
        end
    endtask

    // PLL loss in RUN and again mid-assert; relock gives a full 8-cycle assert.
    task automatic test_pll_loss();
        logic [5:0] exp_seq [20];
        exp_seq = '{6'b101000, 6'b101000,
                    6'b111000, 6'b111000, 6'b111000, 6'b111000, 6'b111000,
                    6'b111000, 6'b111000, 6'b111000, 6'b111000, 6'b111000,
                    6'b111000, 6'b111000, 6'b111000,
                    6'b011000, 6'b011000, 6'b001000, 6'b000100, 6'b000000};
        pll_locked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL pll_loss[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i == 1) pll_locked = 1'b1;
            if (i == 5) pll_locked = 1'b0;
            if (i == 6) pll_locked = 1'b1;
        end
    endtask

    // Observed reset stuck high after entering RELEASE.
    task automatic test_release_timeout();
        logic [5:0] exp;
        ext_raw = 1'b1;
`ifdef PCI_RESET_RELEASE_TIMEOUT_EN
        // 16 RELEASE cycles, then RUN with error; still-high sync re-enters RELEASE.
        for (int i = 0; i < 25; i++) begin
            step();
            if (i == 0)       exp = 6'b000000;
            else if (i == 1)  exp = 6'b010000;
            else if (i <= 17) exp = 6'b011010;
            else if (i == 18) exp = 6'b010111;
            else if (i <= 20) exp = 6'b011011;
            else if (i == 21) exp = 6'b001011;
            else if (i == 22) exp = 6'b000111;
            else if (i == 23) exp = 6'b000011;
            else              exp = 6'b000001;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL release_timeout[%0d]: got %b expected %b", i, obs, exp);
            end
            if (i == 19) ext_raw = 1'b0;
            ext_reset_clear = (i == 23);
        end
`else
        // Without the timeout RELEASE holds as long as the pad stays in reset.
        for (int i = 0; i < 127; i++) begin
            step();
            if (i == 0)        exp = 6'b000000;
            else if (i == 1)   exp = 6'b010000;
            else if (i <= 122) exp = 6'b011010;
            else if (i == 123) exp = 6'b001010;
            else if (i == 124) exp = 6'b000110;
            else if (i == 125) exp = 6'b000010;
            else               exp = 6'b000000;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL release_hold[%0d]: got %b expected %b", i, obs, exp);
            end
            if (i == 121) ext_raw = 1'b0;
            ext_reset_clear = (i == 125);
        end
`endif
        ext_reset_clear = 1'b0;
    endtask

    // Chip reset during ASSERT returns everything to reset values next edge.
    task automatic test_chip_reset_mid_assert();
        logic [5:0] exp;
        sw_reset_req = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            sw_reset_req   = 1'b0;
            pci_reset_comb = (i == 2);
            if (i <= 1)       exp = {6'b101000} | {5'b0, ERR_AFTER_TIMEOUT};
            else if (i == 2)  exp = {6'b111000} | {5'b0, ERR_AFTER_TIMEOUT};
            else if (i <= 11) exp = 6'b111000;
            else              exp = 6'b011000;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL chip_reset[%0d]: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_sw_reset();
        test_ext_reset();
        test_pll_loss();
        test_release_timeout();
        test_chip_reset_mid_assert();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so a broken design cannot stall the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d compares", n_cmp);
        $fatal(1, "time limit");
    end

endmodule : tb_pci_reset_driver
